garuda_prog_rom: RTL and testbench

- Parametrised, loadable multi-program instruction store for CVA6 + Garuda integration benches.
- Replaces fixed 8-word constant test programs with N selectable programs of configurable depth.
- Serves core instruction fetches over a valid/ready request/response interface with configurable read latency and bounded outstanding requests.
- Detects ebreak delivery and counts fetches, so benches can tell when a program has finished.

---
 rtl/garuda_prog_rom.sv | 157 +++++++++++++++
 tb/tb_garuda_prog_rom.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/garuda_prog_rom.sv
// Loadable multi-program instruction store serving valid/ready fetches with fixed latency and credit-bounded outstanding requests.
// Optional macro GARUDA_PROG_ROM_ERR_EN: flags out-of-range/misaligned fetches instead of wrapping the address.
module garuda_prog_rom #(
  parameter int          NUM_PROGS   = 4,
  parameter int          PROG_DEPTH  = 16,
  parameter logic [31:0] BOOT_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 1,
  parameter int          OUTSTANDING = 2,
  localparam int         PGW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1,
  localparam int         IW  = $clog2(PROG_DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           ld_en_i,
  input  logic [PGW-1:0] ld_prog_i,
  input  logic [IW-1:0]  ld_idx_i,
  input  logic [31:0]    ld_data_i,
  input  logic           start_i,
  input  logic [PGW-1:0] prog_sel_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  logic [31:0]    req_addr_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [31:0]    rsp_data_o,
  output logic           rsp_err_o,
  output logic           halted_o,
  output logic [15:0]    fetch_cnt_o
);

  localparam int          PW     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int          CW     = $clog2(OUTSTANDING + 1);
  localparam int          NWORDS = NUM_PROGS * PROG_DEPTH;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic [31:0]       r_mem [NWORDS];
  logic [NWORDS-1:0] r_wb;
  logic [PGW-1:0]    r_prog;
  logic [31:0]       r_fd [OUTSTANDING];
  logic              r_fe [OUTSTANDING];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_fcnt, r_inflight;
  logic              r_halted;
  logic [15:0]       r_cnt;

  logic [31:0]       w_off;
  logic [IW-1:0]     w_idx;
  logic [PGW+IW-1:0] w_raddr, w_waddr;
  logic              w_accept, w_rsp_hs;
  logic              w_rd_err;
  logic [31:0]       w_rd_data;
  logic              w_fin_valid, w_fin_err;
  logic [31:0]       w_fin_data;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_off    = req_addr_i - BOOT_ADDR;
  assign w_idx    = w_off[IW+1:2];
  assign w_raddr  = {r_prog, w_idx};
  assign w_waddr  = {ld_prog_i, ld_idx_i};
  assign w_accept = req_valid_i & req_ready_o;
  assign w_rsp_hs = rsp_valid_o & rsp_ready_i;

`ifdef GARUDA_PROG_ROM_ERR_EN
  // Unsigned offset compare also catches addresses below BOOT_ADDR (they wrap high).
  assign w_rd_err = (w_off >= 32'(4 * PROG_DEPTH)) | (req_addr_i[1:0] != 2'b00);
`else
  logic w_unused;
  assign w_rd_err = 1'b0;
  assign w_unused = ^{w_off[31:IW+2], w_off[1:0]};
`endif

  assign w_rd_data = w_rd_err ? 32'h0 : (r_wb[w_raddr] ? r_mem[w_raddr] : NOP);

  always_ff @(posedge clk_i) begin
    if (ld_en_i) r_mem[w_waddr] <= ld_data_i;
  end

  // Stages before the FIFO: LATENCY-1 registers; the FIFO write itself is the last stage.
  generate
    if (LATENCY == 1) begin : g_nopipe
      assign w_fin_valid = w_accept;
      assign w_fin_data  = w_rd_data;
      assign w_fin_err   = w_rd_err;
    end else begin : g_pipe
      logic        r_pv [LATENCY-1];
      logic        r_pe [LATENCY-1];
      logic [31:0] r_pd [LATENCY-1];
      for (genvar gi = 0; gi < LATENCY - 1; gi++) begin : g_stg
        if (gi == 0) begin : g_first
          always_ff @(posedge clk_i) begin
            if (rst_i) r_pv[gi] <= 1'b0;
            else       r_pv[gi] <= w_accept;
            r_pd[gi] <= w_rd_data;
            r_pe[gi] <= w_rd_err;
          end
        end else begin : g_rest
          always_ff @(posedge clk_i) begin
            if (rst_i) r_pv[gi] <= 1'b0;
            else       r_pv[gi] <= r_pv[gi-1];
            r_pd[gi] <= r_pd[gi-1];
            r_pe[gi] <= r_pe[gi-1];
          end
        end
      end
      assign w_fin_valid = r_pv[LATENCY-2];
      assign w_fin_data  = r_pd[LATENCY-2];
      assign w_fin_err   = r_pe[LATENCY-2];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (w_fin_valid) begin
      r_fd[r_wp] <= w_fin_data;
      r_fe[r_wp] <= w_fin_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wb       <= '0;
      r_prog     <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_fcnt     <= '0;
      r_inflight <= '0;
      r_halted   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (ld_en_i)     r_wb[w_waddr] <= 1'b1;
      if (start_i)     r_prog <= prog_sel_i;
      if (w_fin_valid) r_wp <= f_next(r_wp);
      if (w_rsp_hs)    r_rp <= f_next(r_rp);
      r_fcnt     <= r_fcnt + CW'(w_fin_valid) - CW'(w_rsp_hs);
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_rsp_hs);
      if (start_i) begin
        r_halted <= 1'b0;
        r_cnt    <= '0;
      end else if (w_rsp_hs) begin
        if (rsp_data_o == EBREAK && !rsp_err_o) r_halted <= 1'b1;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Credits come from registered occupancy only; a same-cycle response does not free one.
  assign req_ready_o = r_inflight < CW'(OUTSTANDING);
  assign rsp_valid_o = r_fcnt != '0;
  assign rsp_data_o  = rsp_valid_o ? r_fd[r_rp] : 32'h0;
  assign rsp_err_o   = rsp_valid_o & r_fe[r_rp];
  assign halted_o    = r_halted;
  assign fetch_cnt_o = r_cnt;

endmodule

// File: tb/tb_garuda_prog_rom.sv
// Directed bench for garuda_prog_rom: default instance (LATENCY=1) plus a LATENCY=2 instance for backpressure.
module tb_garuda_prog_rom;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_en = 1'b0;
  logic [1:0]  ld_prog = '0;
  logic [3:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;
  logic        start = 1'b0;
  logic [1:0]  prog_sel = '0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rsp_ready = 1'b1;

  logic        req_ready, rsp_valid, rsp_err, halted;
  logic [31:0] rsp_data;
  logic [15:0] fetch_cnt;
  logic        req_ready2, rsp_valid2, rsp_err2, halted2;
  logic [31:0] rsp_data2;
  logic [15:0] fetch_cnt2;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  logic [31:0] mac [8];
  logic [31:0] b_addr [16];
  logic [31:0] b_exp [16];
  logic        b_err [16];
  logic        b_halt [16];
  int          b_acc [16];
  int          b_rsp [16];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  garuda_prog_rom u_dut (
    .clk_i(clk), .rst_i(rst), .ld_en_i(ld_en), .ld_prog_i(ld_prog), .ld_idx_i(ld_idx),
    .ld_data_i(ld_data), .start_i(start), .prog_sel_i(prog_sel), .req_valid_i(req_valid),
    .req_ready_o(req_ready), .req_addr_i(req_addr), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .halted_o(halted), .fetch_cnt_o(fetch_cnt)
  );

  garuda_prog_rom #(.LATENCY(2), .OUTSTANDING(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .ld_en_i(ld_en), .ld_prog_i(ld_prog), .ld_idx_i(ld_idx),
    .ld_data_i(ld_data), .start_i(start), .prog_sel_i(prog_sel), .req_valid_i(req_valid),
    .req_ready_o(req_ready2), .req_addr_i(req_addr), .rsp_valid_o(rsp_valid2),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data2), .rsp_err_o(rsp_err2),
    .halted_o(halted2), .fetch_cnt_o(fetch_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] p, input logic [3:0] i, input logic [31:0] d);
    ld_en = 1'b1; ld_prog = p; ld_idx = i; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic start_prog(input logic [1:0] p);
    start = 1'b1; prog_sel = p;
    tick();
    start = 1'b0;
  endtask

  // Pipelined fetch of b_addr[0..n-1] on u_dut, comparing each response against b_exp/b_err in order.
  task automatic burst(input int n);
    int sent, got, k;
    sent = 0; got = 0; k = 0;
    rsp_ready = 1'b1;
    while (got < n && k < 100) begin
      req_valid = (sent < n);
      if (sent < n) req_addr = b_addr[sent];
      if (rsp_valid) begin
        check($sformatf("rsp%0d data", got), rsp_data, b_exp[got]);
        check($sformatf("rsp%0d err", got), {31'b0, rsp_err}, {31'b0, b_err[got]});
        b_halt[got] = halted;
        b_rsp[got] = cyc;
        got++;
      end
      if (req_valid && req_ready) begin
        b_acc[sent] = cyc;
        sent++;
      end
      tick();
      k++;
    end
    req_valid = 1'b0;
    if (got < n) check("burst timeout", got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int got, k;
    logic acc;
    mac[0] = 32'h0050_8093; mac[1] = 32'h0071_0113; mac[2] = 32'h0001_8193; mac[3] = 32'h0020_80BB;
    mac[4] = 32'h0030_2023; mac[5] = 32'h0010_0073; mac[6] = 32'h0000_0013; mac[7] = 32'h0000_0013;

    repeat (2) tick();
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset fetch_cnt", {16'b0, fetch_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // MAC8 program: ebreak is the 6th word.
    for (int i = 0; i < 8; i++) load(2'd0, 4'(i), mac[i]);
    start_prog(2'd0);
    for (int i = 0; i < 6; i++) begin
      b_addr[i] = 32'h8000_0000 + 32'(4 * i); b_exp[i] = mac[i]; b_err[i] = 1'b0;
    end
    burst(6);
    check("mac8 halted before 6th hs", {31'b0, b_halt[5]}, 32'd0);
    check("mac8 halted", {31'b0, halted}, 32'd1);
    check("mac8 fetch_cnt", {16'b0, fetch_cnt}, 32'd6);

    // Program select with an unwritten word.
    load(2'd2, 4'd0, 32'h0000_1111);
    start_prog(2'd2);
    check("start clears halted", {31'b0, halted}, 32'd0);
    check("start clears fetch_cnt", {16'b0, fetch_cnt}, 32'd0);
    b_addr[0] = 32'h8000_0000; b_exp[0] = 32'h0000_1111; b_err[0] = 1'b0;
    b_addr[1] = 32'h8000_0004; b_exp[1] = 32'h0000_0013; b_err[1] = 1'b0;
    burst(2);

    // Throughput: 8 back-to-back fetches, one response per cycle, one cycle after acceptance.
    start_prog(2'd0);
    for (int i = 0; i < 8; i++) begin
      b_addr[i] = 32'h8000_0000 + 32'(4 * i); b_exp[i] = mac[i]; b_err[i] = 1'b0;
    end
    burst(8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("tput lat%0d", i), 32'(b_rsp[i] - b_acc[i]), 32'd1);
      check($sformatf("tput slot%0d", i), 32'(b_rsp[i] - b_rsp[0]), 32'(i));
    end
    check("tput fetch_cnt", {16'b0, fetch_cnt}, 32'd8);

    // Out-of-range and misaligned addresses.
    b_addr[0] = 32'h8000_0040; b_addr[1] = 32'h8000_0002;
`ifdef GARUDA_PROG_ROM_ERR_EN
    b_exp[0] = 32'h0; b_err[0] = 1'b1; b_exp[1] = 32'h0; b_err[1] = 1'b1;
`else
    b_exp[0] = mac[0]; b_err[0] = 1'b0; b_exp[1] = mac[0]; b_err[1] = 1'b0;
`endif
    burst(2);

    // Backpressure on the LATENCY=2 instance.
    rst = 1'b1; tick(); rst = 1'b0;
    load(2'd0, 4'd0, 32'hAAAA_0001);
    load(2'd0, 4'd1, 32'hBBBB_0002);
    load(2'd0, 4'd2, 32'hCCCC_0003);
    b_exp[0] = 32'hAAAA_0001; b_exp[1] = 32'hBBBB_0002; b_exp[2] = 32'hCCCC_0003;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    check("bp accept0 ready", {31'b0, req_ready2}, 32'd1);
    tick();
    req_addr = 32'h8000_0004;
    check("bp accept1 ready", {31'b0, req_ready2}, 32'd1);
    tick();
    req_addr = 32'h8000_0008;
    check("bp stall ready", {31'b0, req_ready2}, 32'd0);
    repeat (3) tick();
    check("bp still stalled", {31'b0, req_ready2}, 32'd0);
    check("bp head valid", {31'b0, rsp_valid2}, 32'd1);
    check("bp head data", rsp_data2, b_exp[0]);
    rsp_ready = 1'b1;
    got = 0; k = 0; acc = 1'b0;
    while (got < 3 && k < 50) begin
      if (rsp_valid2) begin
        check($sformatf("bp rsp%0d", got), rsp_data2, b_exp[got]);
        got++;
      end
      if (req_valid && req_ready2) acc = 1'b1;
      tick();
      if (acc) req_valid = 1'b0;
      k++;
    end
    req_valid = 1'b0;
    check("bp 3rd accepted", {31'b0, acc}, 32'd1);
    check("bp responses", 32'(got), 32'd3);
    repeat (4) tick();

    // Reset with two responses queued.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h8000_0000;
    tick();
    req_addr = 32'h8000_0004;
    tick();
    req_valid = 1'b0;
    tick();
    check("rm queued valid", {31'b0, rsp_valid}, 32'd1);
    check("rm queued ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rm rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rm req_ready", {31'b0, req_ready}, 32'd1);
    check("rm fetch_cnt", {16'b0, fetch_cnt}, 32'd0);
    check("rm halted", {31'b0, halted}, 32'd0);
    b_addr[0] = 32'h8000_0000; b_exp[0] = 32'h0000_0013; b_err[0] = 1'b0;
    b_addr[1] = 32'h8000_0008; b_exp[1] = 32'h0000_0013; b_err[1] = 1'b0;
    burst(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
